result_tx_scheduler: RTL and testbench

RESULT_TX_SCHEDULER -- requirements
Module: result_tx_scheduler

---
 rtl/result_tx_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_result_tx_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : result_tx_scheduler
//  Description : Buffers SMA and EMA results in two small FIFOs, arbitrates
//                between them round-robin, and serialises each popped result
//                as a tagged byte frame (TAG, LSB, MSB) into a UART
//                transmitter through a send/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature (macro): TX_CHECKSUM_EN
//    defined   -> a 4th byte TAG ^ LSB ^ MSB is appended to every frame
//    undefined -> frames are exactly 3 bytes
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   clock, all state on rising edge
//    reset_n       in   1   asynchronous active-low reset
//    enable        in   1   allow new frames to start
//    sma_valid     in   1   strobe: sma_result valid
//    sma_result    in  16   SMA result
//    ema_valid     in   1   strobe: ema_result valid
//    ema_result    in  16   EMA result
//    tx_ready      in   1   UART idle, can accept a byte
//    tx_send       out  1   one-cycle pulse: transmit tx_data
//    tx_data       out  8   byte to transmit, held between pulses
//    busy          out  1   FSM outside IDLE
//    overflow_cnt  out  8   saturating count of dropped results
// ============================================================================
module result_tx_scheduler #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] TAG_SMA    = 8'hA1,
  parameter logic [7:0] TAG_EMA    = 8'hE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sma_valid,
  input  logic [15:0] sma_result,
  input  logic        ema_valid,
  input  logic [15:0] ema_result,
  input  logic        tx_ready,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  overflow_cnt
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
`ifdef TX_CHECKSUM_EN
  localparam logic [2:0] c_nbytes = 3'd4;
`else
  localparam logic [2:0] c_nbytes = 3'd3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_SEND     = 3'd2,
    ST_GUARD    = 3'd3,
    ST_WAIT_RDY = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Index 0 = SMA requester, index 1 = EMA requester.
  logic [15:0] r_mem    [2][FIFO_DEPTH];
  logic [c_aw:0] r_wr_ptr [2];
  logic [c_aw:0] r_rd_ptr [2];
  logic [15:0] w_din    [2];
  logic [15:0] w_head   [2];
  logic [1:0]  w_valid;
  logic [1:0]  w_empty;
  logic [1:0]  w_full;
  logic [1:0]  w_push;
  logic [1:0]  w_pop;
  logic [1:0]  w_drop;

  logic        w_grant_ema;
  logic        r_rr_ema;      // 1: EMA wins the next contested arbitration
  logic [15:0] r_frame;
  logic        r_frame_ema;
  logic [2:0]  r_byte_idx;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_overflow;
  logic [7:0]  w_tag;
  logic [7:0]  w_cur_byte;
  logic [8:0]  w_ovf_sum;
  logic        w_tx_send;

  assign w_valid = {ema_valid, sma_valid};
  assign w_din[0] = sma_result;
  assign w_din[1] = ema_result;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < 2; i++) begin
      w_head[i]  = r_mem[i][r_rd_ptr[i][c_aw-1:0]];
      w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
      // Full when the wrap bits differ but the addresses coincide.
      w_full[i]  = (r_wr_ptr[i][c_aw] != r_rd_ptr[i][c_aw]) &&
                   (r_wr_ptr[i][c_aw-1:0] == r_rd_ptr[i][c_aw-1:0]);
    end
  end

  // Round robin: the pointer only moves on a contested grant, so a lone
  // requester being served does not steal the other's turn.
  assign w_grant_ema = !w_empty[1] && (w_empty[0] || r_rr_ema);
  assign w_pop[0]    = (r_state == ST_ARB) && !w_empty[0] && !w_grant_ema;
  assign w_pop[1]    = (r_state == ST_ARB) && w_grant_ema;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is kept.
  assign w_push = w_valid & (~w_full | w_pop);
  assign w_drop = w_valid & w_full & ~w_pop;

  assign w_ovf_sum = {1'b0, r_overflow} + {8'd0, w_drop[0]} + {8'd0, w_drop[1]};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i][c_aw-1:0]] <= w_din[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
      end
    end
  end

  // Frame byte selection.
  always_comb begin
    w_tag = r_frame_ema ? TAG_EMA : TAG_SMA;
    case (r_byte_idx)
      3'd0:    w_cur_byte = w_tag;
      3'd1:    w_cur_byte = r_frame[7:0];
      3'd2:    w_cur_byte = r_frame[15:8];
`ifdef TX_CHECKSUM_EN
      3'd3:    w_cur_byte = w_tag ^ r_frame[7:0] ^ r_frame[15:8];
`endif
      default: w_cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_send    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && (w_empty != 2'b11)) w_state_next = ST_ARB;
      end
      ST_ARB: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          w_tx_send    = 1'b1;
          w_state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        // tx_ready may still read high here before the UART deasserts it.
        w_state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (tx_ready) w_state_next = (r_byte_idx == c_nbytes) ? ST_IDLE : ST_SEND;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ema    <= 1'b0;
      r_frame     <= 16'h0000;
      r_frame_ema <= 1'b0;
      r_byte_idx  <= 3'd0;
      r_tx_data   <= 8'h00;
      r_overflow  <= 8'h00;
    end else begin
      r_overflow <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
      if (r_state == ST_ARB) begin
        r_frame     <= w_grant_ema ? w_head[1] : w_head[0];
        r_frame_ema <= w_grant_ema;
        r_byte_idx  <= 3'd0;
        if (w_empty == 2'b00) r_rr_ema <= !w_grant_ema;
      end
      if (w_tx_send) begin
        r_tx_data  <= w_cur_byte;
        r_byte_idx <= r_byte_idx + 3'd1;
      end
    end
  end

  // The byte appears on tx_data in the pulse cycle itself, then is held.
  assign tx_send      = w_tx_send;
  assign tx_data      = w_tx_send ? w_cur_byte : r_tx_data;
  assign busy         = (r_state != ST_IDLE);
  assign overflow_cnt = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_tx_scheduler
//  Description : Scoreboard bench for result_tx_scheduler. Stimulus pushes the
//                expected byte stream into a queue; a monitor compares every
//                transmitted byte against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sma_valid;
  logic [15:0] sma_result;
  logic        ema_valid;
  logic [15:0] ema_result;
  logic        tx_ready;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  overflow_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;
  logic [7:0] mon_exp;
  logic       prev_send = 1'b0;
  int         lat;

  always #5 clk = ~clk;

  result_tx_scheduler #(
    .FIFO_DEPTH(4),
    .TAG_SMA(8'hA1),
    .TAG_EMA(8'hE1)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .sma_valid(sma_valid),
    .sma_result(sma_result),
    .ema_valid(ema_valid),
    .ema_result(ema_result),
    .tx_ready(tx_ready),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .busy(busy),
    .overflow_cnt(overflow_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic ema, input logic [15:0] r);
    logic [7:0] tag;
    tag = ema ? 8'hE1 : 8'hA1;
    exp_q.push_back(tag);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(tag ^ r[7:0] ^ r[15:8]);
`endif
  endtask

  task automatic strobe(input logic s, input logic [15:0] sr, input logic e, input logic [15:0] er);
    @(negedge clk);
    sma_valid  = s;
    sma_result = sr;
    ema_valid  = e;
    ema_result = er;
    @(negedge clk);
    sma_valid = 1'b0;
    ema_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_send(input string name, input int budget);
    int n;
    n = 0;
    while (!tx_send && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Monitor: compare every transmitted byte with the scoreboard and check
  // that tx_data holds between pulses.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_last  = 8'h00;
      prev_send = 1'b0;
    end else begin
      if (tx_send) begin
        check("send_while_ready", 32'(tx_ready), 32'd1);
        check("send_not_adjacent", 32'(prev_send), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send: got tx_data=%0h expected no send", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(mon_exp));
          exp_last = mon_exp;
        end
      end else begin
        check("tx_data_hold", 32'(tx_data), 32'(exp_last));
      end
      prev_send = tx_send;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b1;
    enable     = 1'b0;
    sma_valid  = 1'b0;
    ema_valid  = 1'b0;
    sma_result = 16'h0000;
    ema_result = 16'h0000;
    tx_ready   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Single SMA frame with tx_ready held high; first pulse 3 cycles later.
    push_frame(1'b0, 16'h1234);
    @(negedge clk);
    sma_valid  = 1'b1;
    sma_result = 16'h1234;
    @(negedge clk);
    sma_valid = 1'b0;
    lat = 1;
    while (!tx_send && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_send_latency", 32'(lat), 32'd3);
    wait_drain("drain_t1", 100);

    // Simultaneous pairs: SMA first after reset, then EMA first.
    push_frame(1'b0, 16'h0001);
    push_frame(1'b1, 16'h0002);
    strobe(1'b1, 16'h0001, 1'b1, 16'h0002);
    wait_drain("drain_pair1", 200);
    push_frame(1'b1, 16'h0004);
    push_frame(1'b0, 16'h0003);
    strobe(1'b1, 16'h0003, 1'b1, 16'h0004);
    wait_drain("drain_pair2", 200);

    // Overflow: five results into a four-entry FIFO while nothing drains.
    enable   = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b1, 16'h0010 + 16'(i), 1'b0, 16'h0000);
    check("ovf_one_drop", 32'(overflow_cnt), 32'd1);
    check("idle_while_disabled", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) push_frame(1'b0, 16'h0010 + 16'(i));
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_waiting_ready", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    wait_drain("drain_overflow", 300);
    check("ovf_after_drain", 32'(overflow_cnt), 32'd1);

    // Enable dropped after the tag byte: the frame completes, then holds.
    push_frame(1'b0, 16'h5566);
    strobe(1'b1, 16'h5566, 1'b0, 16'h0000);
    strobe(1'b1, 16'h7788, 1'b0, 16'h0000);
    wait_send("wait_tag_t4", 50);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("hold_busy_low", 32'(busy), 32'd0);
    check("hold_frame_done", 32'(exp_q.size()), 32'd0);
    push_frame(1'b0, 16'h7788);
    enable = 1'b1;
    wait_drain("drain_t4", 200);

    // Reset after the first byte of a frame discards everything.
    exp_q.push_back(8'hA1);
    strobe(1'b1, 16'h9ABC, 1'b0, 16'h0000);
    strobe(1'b1, 16'h1111, 1'b0, 16'h0000);
    wait_send("wait_tag_t5", 50);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_tx_send", 32'(tx_send), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overflow", 32'(overflow_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    // Saturation: fill both FIFOs, then 300 drops (two per strobe).
    enable = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b1, 16'(i), 1'b1, 16'(i));
    check("sat_no_drop_yet", 32'(overflow_cnt), 32'd0);
    strobe(1'b1, 16'h00AA, 1'b1, 16'h00BB);
    check("sat_dual_drop", 32'(overflow_cnt), 32'd2);
    for (int i = 0; i < 149; i++) strobe(1'b1, 16'h00AA, 1'b1, 16'h00BB);
    check("sat_255", 32'(overflow_cnt), 32'd255);
    check("sat_busy", 32'(busy), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
